// File: rtl/regbank_pkg.sv
// Shared definitions for the register bank / operand-fetch sequencer:
// ALU funct codes, sequencer state encoding and default geometry.
package regbank_pkg;

  localparam int REGBANK_NREG   = 32;
  localparam int REGBANK_DATA_W = 32;
  localparam int REGBANK_ADDR_W = 5;

  typedef enum logic [5:0] {
    FN_ADD = 6'd0,
    FN_SUB = 6'd1,
    FN_AND = 6'd2,
    FN_OR  = 6'd3,
    FN_XOR = 6'd4,
    FN_NOT = 6'd5,
    FN_SLA = 6'd6,
    FN_SRA = 6'd7,
    FN_SRL = 6'd8
  } funct_e;

  localparam logic [5:0] FUNCT_MAX = 6'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

endpackage

// File: rtl/regbank_rf.sv
// Register array: three combinational read ports (A, B, debug) and one
// synchronous write port. With REGBANK_R0_ZERO_EN defined, register 0 is
// hard-wired to zero: it reads as 0 everywhere and writes to it are dropped.
module regbank_rf
  import regbank_pkg::*;
#(
  parameter int NREG   = REGBANK_NREG,
  parameter int DATA_W = REGBANK_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        ra_addr,
  input  logic [4:0]        rb_addr,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREG];
  logic              we_eff;

`ifdef REGBANK_R0_ZERO_EN
  assign we_eff = we && (waddr != '0);

  // Read ports with register 0 forced to zero
  always_comb begin
    ra_data  = (ra_addr  == '0) ? '0 : regs[ra_addr];
    rb_data  = (rb_addr  == '0) ? '0 : regs[rb_addr];
    dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
  end
`else
  assign we_eff = we;

  // Plain combinational read ports
  always_comb begin
    ra_data  = regs[ra_addr];
    rb_data  = regs[rb_addr];
    dbg_data = regs[dbg_addr];
  end
`endif

  // Register storage: cleared by reset, single write per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we_eff) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/regbank_exec_seq.sv
// Register bank plus operand-fetch / writeback sequencer feeding the ALU.
// One R-type instruction at a time: IDLE -> READ -> EXEC -> WB -> IDLE.
// Optional build macro: REGBANK_R0_ZERO_EN (register 0 hard-wired to zero,
// implemented inside regbank_rf).
module regbank_exec_seq
  import regbank_pkg::*;
#(
  parameter int NREG   = REGBANK_NREG,
  parameter int DATA_W = REGBANK_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic              ld_en,
  input  logic [4:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_shamt,
  output logic [5:0]        alu_funct,
  input  logic [DATA_W-1:0] alu_res,
  output logic              wb_done,
  output logic              err,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state, state_nxt;
  logic [4:0]        rs_q, rt_q, rd_q, shamt_q;
  logic [5:0]        funct_q;
  logic              illegal;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_a, rf_b;

  assign instr_ready = (state == IDLE);
  assign illegal     = (funct_q > FUNCT_MAX);

  regbank_rf #(
    .NREG   (NREG),
    .DATA_W (DATA_W)
  ) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .ra_addr  (rs_q),
    .rb_addr  (rt_q),
    .dbg_addr (dbg_addr),
    .ra_data  (rf_a),
    .rb_data  (rf_b),
    .dbg_data (dbg_data)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and write-port mux: loads only in IDLE, writeback in WB
  always_comb begin
    state_nxt = state;
    rf_we     = 1'b0;
    rf_waddr  = ld_addr;
    rf_wdata  = ld_data;
    unique case (state)
      IDLE: begin
        rf_we = ld_en;
        if (instr_valid) state_nxt = READ;
      end
      READ: state_nxt = illegal ? IDLE : EXEC;
      EXEC: state_nxt = WB;
      WB: begin
        rf_we     = 1'b1;
        rf_waddr  = rd_q;
        rf_wdata  = alu_res;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction field latch on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      shamt_q <= '0;
      funct_q <= '0;
    end else if (state == IDLE && instr_valid) begin
      rs_q    <= rs;
      rt_q    <= rt;
      rd_q    <= rd;
      shamt_q <= shamt;
      funct_q <= funct;
    end
  end

  // ALU operand registers, loaded in READ and held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_shamt <= '0;
      alu_funct <= '0;
    end else if (state == READ) begin
      alu_a     <= rf_a;
      alu_b     <= rf_b;
      alu_shamt <= shamt_q;
      alu_funct <= funct_q;
    end
  end

  // One-cycle status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_done <= 1'b0;
      err     <= 1'b0;
    end else begin
      wb_done <= (state == WB);
      err     <= (state == READ) && illegal;
    end
  end

endmodule

// File: tb/tb_regbank_exec_seq.sv
// Directed bench for regbank_exec_seq with a behavioural registered ALU
// and a writeback scoreboard.
module tb_regbank_exec_seq;
  import regbank_pkg::*;

`ifdef REGBANK_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, instr_ready;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [4:0]  alu_shamt;
  logic [5:0]  alu_funct;
  logic        wb_done, err;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          acc_cyc = 0;
  int          last_acc = 0;

  regbank_exec_seq #(.NREG(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_funct(alu_funct),
    .alu_res(alu_res), .wb_done(wb_done), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(input logic [31:0] a, b, input logic [4:0] sh,
                                        input logic [5:0] fn);
    case (fn)
      FN_ADD:  return a + b;
      FN_SUB:  return a - b;
      FN_AND:  return a & b;
      FN_OR:   return a | b;
      FN_XOR:  return a ^ b;
      FN_NOT:  return ~a;
      FN_SLA:  return a << sh;
      FN_SRA:  return $unsigned($signed(a) >>> sh);
      FN_SRL:  return a >> sh;
      default: return '0;
    endcase
  endfunction

  // Registered ALU model standing in for the downstream datapath
  always @(posedge clk) alu_res <= alu_f(alu_a, alu_b, alu_shamt, alu_funct);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void wr_model(input logic [4:0] a, input logic [31:0] d);
    if (!(R0Z && a == 5'd0)) model[a] = d;
  endfunction

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk); #1;
    ld_en = 1'b0;
    wr_model(a, d);
  endtask

  task automatic peek(input string tag, input logic [4:0] a);
    dbg_addr = a; #1;
    chk(tag, dbg_data, model[a]);
  endtask

  // Issue one instruction and follow it cycle by cycle; returns in the
  // cycle where instr_ready is high again so a follow-on can issue at once.
  task automatic exec_instr(input string tag, input logic [4:0] rs_i, rt_i, rd_i, sh_i,
                            input logic [5:0] fn_i, input bit stray_ld);
    int n;
    logic [31:0] a, b;
    logic legal;
    exp_t e;
    n = 0;
    while (instr_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    chk({tag, "_ready_in"}, {31'd0, instr_ready}, 32'd1);
    a = model[rs_i]; b = model[rt_i];
    legal = (fn_i <= FUNCT_MAX);
    if (legal) sb.push_back('{rd: rd_i, val: alu_f(a, b, sh_i, fn_i)});
    last_acc = acc_cyc; acc_cyc = cyc;
    instr_valid = 1'b1; rs = rs_i; rt = rt_i; rd = rd_i; shamt = sh_i; funct = fn_i;
    @(negedge clk); #1;                      // READ
    instr_valid = 1'b0; ld_en = 1'b0;
    if (stray_ld) begin ld_en = 1'b1; ld_addr = rs_i; ld_data = 32'hDEAD_BEEF; end
    chk({tag, "_ready_read"}, {31'd0, instr_ready}, 32'd0);
    @(negedge clk); #1;                      // EXEC or back in IDLE
    chk({tag, "_alu_a"}, alu_a, a);
    chk({tag, "_alu_b"}, alu_b, b);
    chk({tag, "_alu_funct"}, {26'd0, alu_funct}, {26'd0, fn_i});
    chk({tag, "_alu_shamt"}, {27'd0, alu_shamt}, {27'd0, sh_i});
    if (!legal) begin
      chk({tag, "_err"}, {31'd0, err}, 32'd1);
      chk({tag, "_ready_err"}, {31'd0, instr_ready}, 32'd1);
      repeat (3) begin
        chk({tag, "_no_wb"}, {31'd0, wb_done}, 32'd0);
        @(negedge clk); #1;
      end
      chk({tag, "_err_once"}, {31'd0, err}, 32'd0);
      return;
    end
    chk({tag, "_ready_exec"}, {31'd0, instr_ready}, 32'd0);
    @(negedge clk); #1;                      // WB
    ld_en = 1'b0;
    chk({tag, "_ready_wb"}, {31'd0, instr_ready}, 32'd0);
    chk({tag, "_wb_early"}, {31'd0, wb_done}, 32'd0);
    @(negedge clk); #1;                      // IDLE, wb_done pulse
    chk({tag, "_wb_done"}, {31'd0, wb_done}, 32'd1);
    chk({tag, "_ready_back"}, {31'd0, instr_ready}, 32'd1);
    if (wb_done === 1'b1) begin
      n_tests++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL %s_sb: observed wb_done with empty scoreboard, expected pending entry", tag);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        wr_model(e.rd, e.val);
        peek({tag, "_result"}, e.rd);
      end
    end
  endtask

  initial begin
    instr_valid = 1'b0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Reset, with stray load / instruction that must be ignored
    rst = 1'b1; ld_en = 1'b1; ld_addr = 5'd7; ld_data = 32'h1111_1111; instr_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1; instr_valid = 1'b0; ld_en = 1'b0; rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_wb_done", {31'd0, wb_done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    for (int i = 0; i < 32; i++) peek("rst_reg", i[4:0]);

    // ADD r3 = r1 + r2, with a load attempted mid-instruction (ignored)
    load(5'd1, 32'd5);
    load(5'd2, 32'd3);
    exec_instr("add", 5'd1, 5'd2, 5'd3, 5'd0, FN_ADD, 1'b1);
    @(negedge clk); #1;
    chk("add_wb_once", {31'd0, wb_done}, 32'd0);
    peek("add_r1_kept", 5'd1);

    // SUB then back-to-back ADD using the SUB result
    exec_instr("sub", 5'd2, 5'd1, 5'd4, 5'd0, FN_SUB, 1'b0);
    chk("sub_r4", model[4], 32'hFFFF_FFFE);
    exec_instr("add2", 5'd4, 5'd1, 5'd5, 5'd0, FN_ADD, 1'b0);
    chk("b2b_gap", acc_cyc - last_acc, 32'd4);
    chk("add2_r5", model[5], 32'h0000_0003);

    // Illegal funct: err pulse, no writeback
    exec_instr("illegal", 5'd1, 5'd2, 5'd6, 5'd0, 6'd9, 1'b0);
    peek("illegal_r6", 5'd6);

    // Register 0 as destination, and a direct load to r0
    exec_instr("r0", 5'd1, 5'd2, 5'd0, 5'd0, FN_ADD, 1'b0);
    chk("r0_value", model[0], R0Z ? 32'd0 : 32'd8);
    load(5'd0, 32'h77);
    peek("r0_load", 5'd0);

    // Load and accept in the same cycle: READ must see the new value
    ld_en = 1'b1; ld_addr = 5'd9; ld_data = 32'h100; wr_model(5'd9, 32'h100);
    exec_instr("ld_acc", 5'd9, 5'd1, 5'd10, 5'd0, FN_XOR, 1'b0);
    chk("ld_acc_r10", model[10], 32'h105);

    // Arithmetic shift right of a negative value
    load(5'd11, 32'h8000_0000);
    exec_instr("sra", 5'd11, 5'd0, 5'd12, 5'd4, FN_SRA, 1'b0);
    chk("sra_r12", model[12], 32'hF800_0000);

    // Reset asserted in EXEC aborts the instruction
    instr_valid = 1'b1; rs = 5'd1; rt = 5'd2; rd = 5'd13; funct = FN_ADD; shamt = '0;
    @(negedge clk); #1; instr_valid = 1'b0;  // READ
    @(negedge clk); #1;                       // EXEC
    rst = 1'b1; #1;
    chk("rst_exec_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_exec_alu_a", alu_a, 32'd0);
    chk("rst_exec_alu_b", alu_b, 32'd0);
    @(negedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    repeat (4) begin
      chk("rst_exec_no_wb", {31'd0, wb_done}, 32'd0);
      @(negedge clk); #1;
    end
    for (int i = 0; i < 32; i++) peek("rst_exec_reg", i[4:0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
